// File: rtl/thermal_head_stream_axi.sv
// Captures a thermal head's serial line and multi-strobe burns, queues burned lines, and streams them as AXI-Stream beats.
// Ticks lag mech edges by SYNC_STAGES+1 cycles; push coincides with the end tick; the FIFO holds lines while axi_ready is low.
module thermal_head_stream_axi #(
  parameter int HEAD_WIDTH   = 384,
  parameter int STROBE_COUNT = 6,
  parameter int BEAT_WIDTH   = 32,
  parameter int LINE_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mech_clk,
  input  logic                            mech_data,
  input  logic                            mech_latch,
  input  logic [STROBE_COUNT-1:0]         mech_dst,
  input  logic                            axi_ready,
  output logic                            axi_valid,
  output logic [BEAT_WIDTH-1:0]           axi_data,
  output logic                            axi_last,
  output logic [STROBE_COUNT-1:0]         axi_user,
  output logic [$clog2(LINE_DEPTH+1)-1:0] fifo_level,
  output logic [15:0]                     overflow_count,
  output logic                            head_active_start_tick,
  output logic                            head_active_end_tick
);
  localparam int G         = HEAD_WIDTH / STROBE_COUNT;
  localparam int NUM_BEATS = HEAD_WIDTH / BEAT_WIDTH;
  localparam int BIW       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int PW        = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam int LW        = $clog2(LINE_DEPTH + 1);

  typedef enum logic {IDLE, BURN} burn_state_t;

  logic [SYNC_STAGES-1:0]  clk_sr, data_sr, latch_sr;
  logic [STROBE_COUNT-1:0] dst_sr [SYNC_STAGES];
  logic                    clk_sync, data_sync, latch_sync;
  logic [STROBE_COUNT-1:0] dst_sync;
  logic                    clk_prev, latch_prev, shift_en, latch_en;
  logic [HEAD_WIDTH-1:0]   shift_reg, latch_reg, dot_mask, push_dots;

  burn_state_t             state, state_nxt;
  logic [STROBE_COUNT-1:0] mask, mask_nxt;
  logic                    start_nxt, end_nxt;

  logic [HEAD_WIDTH-1:0]   line_mem [LINE_DEPTH];
  logic [STROBE_COUNT-1:0] user_mem [LINE_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           count;
  logic [BIW-1:0]          beat_idx;
  logic                    push_vld, full, pop, push_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sr   <= '0;
      data_sr  <= '0;
      latch_sr <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) dst_sr[s] <= '0;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], mech_clk};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], mech_data};
      latch_sr <= {latch_sr[SYNC_STAGES-2:0], mech_latch};
      dst_sr[0] <= mech_dst;
      for (int s = 1; s < SYNC_STAGES; s++) dst_sr[s] <= dst_sr[s-1];
    end
  end

  assign clk_sync   = clk_sr[SYNC_STAGES-1];
  assign data_sync  = data_sr[SYNC_STAGES-1];
  assign latch_sync = latch_sr[SYNC_STAGES-1];
  assign dst_sync   = dst_sr[SYNC_STAGES-1];
  assign shift_en   = clk_sync & ~clk_prev;
  assign latch_en   = latch_prev & ~latch_sync;

  // latch_reg takes the pre-shift value when both edges land together
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_prev   <= 1'b0;
      latch_prev <= 1'b0;
      shift_reg  <= '0;
      latch_reg  <= '0;
    end else begin
      clk_prev   <= clk_sync;
      latch_prev <= latch_sync;
      if (shift_en) shift_reg <= {shift_reg[HEAD_WIDTH-2:0], data_sync};
      if (latch_en) latch_reg <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                  <= IDLE;
      mask                   <= '0;
      head_active_start_tick <= 1'b0;
      head_active_end_tick   <= 1'b0;
    end else begin
      state                  <= state_nxt;
      mask                   <= mask_nxt;
      head_active_start_tick <= start_nxt;
      head_active_end_tick   <= end_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|dst_sync) begin
          state_nxt = BURN;
          start_nxt = 1'b1;
          mask_nxt  = dst_sync;
        end
      end
      BURN: begin
        mask_nxt = mask | dst_sync;
        if (dst_sync == '0) begin
          state_nxt = IDLE;
          end_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mask is held after the burn, so the end-tick cycle sees the final strobe set
  always_comb begin
    dot_mask = '0;
    for (int d = 0; d < HEAD_WIDTH; d++) dot_mask[d] = mask[d / G];
  end

  assign push_dots = latch_reg & dot_mask;
  assign push_vld  = head_active_end_tick;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LINE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == LW'(LINE_DEPTH));
  assign pop     = axi_valid & axi_ready & axi_last;
  assign push_ok = push_vld & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      line_mem[wr_ptr] <= push_dots;
      user_mem[wr_ptr] <= mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      beat_idx       <= '0;
      overflow_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push_vld && !push_ok && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 1'b1;
      if (axi_valid && axi_ready)
        beat_idx <= axi_last ? '0 : beat_idx + 1'b1;
    end
  end

  // outputs come from registers only, so they hold while ready is low
  assign axi_valid  = (count != '0);
  assign axi_last   = axi_valid && (beat_idx == BIW'(NUM_BEATS - 1));
  assign axi_user   = axi_valid ? user_mem[rd_ptr] : '0;
  assign axi_data   = axi_valid ? line_mem[rd_ptr][int'(beat_idx) * BEAT_WIDTH +: BEAT_WIDTH] : '0;
  assign fifo_level = count;

endmodule
